// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state debounce FSM with registered outputs.
// Define BTN_LONG_PRESS_EN to add the btn_long output and its held-press counter.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = 100000000,
  parameter int LONG_W          = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_level
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic btn_long
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 ||
      longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end

  if (LONG_CYCLES < 2 ||
      longint'(LONG_CYCLES) > (longint'(1) << LONG_W) - 1) begin : g_bad_long
    $error("LONG_CYCLES out of range for LONG_W");
  end

  logic sync_meta;
  logic sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic             clean_d, level_d;

  // NOTE: every variable gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state;
    count_d = count;
    clean_d = 1'b0;
    level_d = btn_level;
    case (state)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          count_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count == DB_MAX) begin
          state_d = PRESSED;
          count_d = '0;
          level_d = 1'b1;
          clean_d = 1'b1;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          count_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = PRESSED;
          count_d = '0;
        end else if (count == DB_MAX) begin
          state_d = IDLE;
          count_d = '0;
          level_d = 1'b0;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      btn_clean <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      btn_clean <= clean_d;
      btn_level <= level_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt, long_cnt_d;
  logic              long_fired, long_fired_d;
  logic              long_d;

  // Only a fresh press restarts the hold timer; a glitch back from RELEASE_WAIT keeps timing the same press.
  always_comb begin
    long_cnt_d   = long_cnt;
    long_fired_d = long_fired;
    long_d       = 1'b0;
    if (state == PRESS_WAIT && state_d == PRESSED) begin
      long_cnt_d   = '0;
      long_fired_d = 1'b0;
    end else if (state == PRESSED || state == RELEASE_WAIT) begin
      if (long_cnt == LONG_MAX) begin
        if (!long_fired) begin
          long_d       = 1'b1;
          long_fired_d = 1'b1;
        end
      end else begin
        long_cnt_d = long_cnt + LONG_W'(1);
      end
      if (state_d == IDLE) begin
        long_cnt_d   = '0;
        long_fired_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_cnt   <= '0;
      long_fired <= 1'b0;
      btn_long   <= 1'b0;
    end else begin
      long_cnt   <= long_cnt_d;
      long_fired <= long_fired_d;
      btn_long   <= long_d;
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
// Reference model: the debounced level flips after DB+1 consecutive disagreeing samples of btn_raw delayed two edges.
module tb_button_debouncer;

  localparam int DB = 4;
  localparam int LC = 16;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_clean;
  logic btn_level;
`ifdef BTN_LONG_PRESS_EN
  logic btn_long;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (3),
    .LONG_CYCLES    (LC),
    .LONG_W         (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .btn_level(btn_level)
`ifdef BTN_LONG_PRESS_EN
    ,
    .btn_long (btn_long)
`endif
  );

  // Behavioural model state.
  logic m_h1, m_h2, m_seen, m_level, m_clean;
  int   m_run;
`ifdef BTN_LONG_PRESS_EN
  logic m_long;
  int   m_age;
`endif

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_level = 0; m_clean = 0; m_run = 0;
`ifdef BTN_LONG_PRESS_EN
    m_long = 0; m_age = 0;
`endif
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_seen  = m_h2;
      m_h2    = m_h1;
      m_h1    = btn_raw;
      m_clean = 0;
`ifdef BTN_LONG_PRESS_EN
      m_long = 0;
      if (m_level) begin
        m_age++;
        if (m_age == LC) m_long = 1;
      end
`endif
      if (m_seen != m_level) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_level = m_seen;
          m_run   = 0;
          m_clean = m_seen;
`ifdef BTN_LONG_PRESS_EN
          if (m_seen) m_age = 0;
`endif
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Drive btn_raw from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic tick(input logic v);
    btn_raw = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      btn_raw = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (btn_clean !== 1'b0 || btn_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold i=%0d clean=%b level=%b expected 0/0", i, btn_clean, btn_level);
      end
    end
    btn_raw = 0;
    rst     = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0);
      checks++;
      if (btn_clean !== 1'b0 || btn_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle i=%0d clean=%b level=%b expected 0/0", i, btn_clean, btn_level);
      end
    end
  endtask

  task automatic test_latency();
    for (int k = 0; k < 12; k++) begin
      tick(1);
      checks++;
      if (btn_clean !== (k == 6) || btn_level !== (k >= 6)) begin
        errors++;
        $display("FAIL latency edge=%0d clean=%b level=%b expected %b/%b",
                 k, btn_clean, btn_level, (k == 6), (k >= 6));
      end
      checks++;
      if (btn_clean !== m_clean || btn_level !== m_level) begin
        errors++;
        $display("FAIL latency_model edge=%0d clean=%b level=%b expected %b/%b",
                 k, btn_clean, btn_level, m_clean, m_level);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 10; k++) begin
      tick(k < 2 ? 1'b0 : 1'b1);
      checks++;
      if (btn_clean !== 1'b0 || btn_level !== 1'b1) begin
        errors++;
        $display("FAIL glitch edge=%0d clean=%b level=%b expected 0/1", k, btn_clean, btn_level);
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick(0);
      checks++;
      if (btn_clean !== 1'b0 || btn_level !== (k < 6)) begin
        errors++;
        $display("FAIL release edge=%0d clean=%b level=%b expected 0/%b",
                 k, btn_clean, btn_level, (k < 6));
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 6; k++) begin
        tick(k < 3 ? 1'b1 : 1'b0);
        checks++;
        if (btn_clean !== 1'b0 || btn_level !== 1'b0) begin
          errors++;
          $display("FAIL bounce rep=%0d edge=%0d clean=%b level=%b expected 0/0",
                   r, k, btn_clean, btn_level);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int k = 0; k < 3; k++) tick(1);
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if (btn_clean !== 1'b0 || btn_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_async clean=%b level=%b expected 0/0", btn_clean, btn_level);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (btn_clean !== 1'b0 || btn_level !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold i=%0d clean=%b level=%b expected 0/0", k, btn_clean, btn_level);
      end
    end
    rst = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (btn_clean === 1'b1) pulses++;
      checks++;
      if (btn_clean !== (k == 6) || btn_level !== (k >= 6)) begin
        errors++;
        $display("FAIL reset_repress edge=%0d clean=%b level=%b expected %b/%b",
                 k, btn_clean, btn_level, (k == 6), (k >= 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL reset_repress_count pulses=%0d expected 1", pulses);
    end
    for (int k = 0; k < 10; k++) tick(0);
  endtask

  task automatic test_long_hold();
    int nclean = 0;
    int rise   = -1;
`ifdef BTN_LONG_PRESS_EN
    int nlong  = 0;
    int lp     = -1;
`endif
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (btn_clean === 1'b1) nclean++;
      if (btn_level === 1'b1 && rise < 0) rise = k;
`ifdef BTN_LONG_PRESS_EN
      if (btn_long === 1'b1) begin
        nlong++;
        lp = k;
      end
      checks++;
      if (btn_long !== m_long) begin
        errors++;
        $display("FAIL long_model edge=%0d long=%b expected %b", k, btn_long, m_long);
      end
`endif
    end
    checks++;
    if (nclean != 1 || rise != 6) begin
      errors++;
      $display("FAIL hold_clean pulses=%0d rise_edge=%0d expected 1/6", nclean, rise);
    end
`ifdef BTN_LONG_PRESS_EN
    checks++;
    if (nlong != 1 || lp - rise != LC) begin
      errors++;
      $display("FAIL long_pulse count=%0d offset=%0d expected 1/%0d", nlong, lp - rise, LC);
    end
`endif
    for (int k = 0; k < 10; k++) tick(0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 80; s++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        tick(v);
        checks++;
        if (btn_clean !== m_clean || btn_level !== m_level) begin
          errors++;
          $display("FAIL random seg=%0d clean=%b level=%b expected %b/%b",
                   s, btn_clean, btn_level, m_clean, m_level);
        end
`ifdef BTN_LONG_PRESS_EN
        checks++;
        if (btn_long !== m_long) begin
          errors++;
          $display("FAIL random_long seg=%0d long=%b expected %b", s, btn_long, m_long);
        end
`endif
      end
    end
  endtask

  initial begin
    rst     = 1;
    btn_raw = 0;
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
